pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 106 ++++++++++
 tb/tb_pipe_stage_reg.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a one-entry skid buffer so in_ready never
// depends combinationally on out_ready. It also supports flush and counts output transfers.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  xfer_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state_reg;
    logic [DATA_W-1:0]   main_data_reg;
    logic [CTRL_W-1:0]   main_ctrl_reg;
    logic [DATA_W-1:0]   skid_data_reg;
    logic [CTRL_W-1:0]   skid_ctrl_reg;
    logic [CNT_W-1:0]    xfer_count_reg;
    logic [CNT_W-1:0]    xfer_count_next;
    logic                in_xfer;
    logic                out_xfer;

    // in_ready comes only from held state and reset, never from out_ready.
    assign in_ready        = reset & (state_reg != FULL);
    assign out_valid       = (state_reg != EMPTY);
    assign out_data        = main_data_reg;
    assign occupancy       = state_reg;
    assign xfer_count      = xfer_count_reg;
    assign in_xfer         = in_valid & in_ready;
    assign out_xfer        = out_valid & out_ready;
    assign xfer_count_next = xfer_count_reg + CNT_W'(1);

    // A bubble must never carry write-enable/select bits downstream.
    genvar gi;
    generate
        for (gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_mask
            assign out_ctrl[gi] = main_ctrl_reg[gi] & out_valid;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= EMPTY;
            main_data_reg  <= '0;
            main_ctrl_reg  <= '0;
            skid_data_reg  <= '0;
            skid_ctrl_reg  <= '0;
            xfer_count_reg <= '0;
        end else begin
            // An output transfer in a flush cycle still completed downstream.
            if (out_xfer)
                xfer_count_reg <= xfer_count_next;

            if (flush) begin
                state_reg <= EMPTY;
            end else begin
                case (state_reg)
                    EMPTY: begin
                        if (in_xfer) begin
                            state_reg     <= ONE;
                            main_data_reg <= in_data;
                            main_ctrl_reg <= in_ctrl;
                        end
                    end
                    ONE: begin
                        if (in_xfer && out_ready) begin
                            main_data_reg <= in_data;
                            main_ctrl_reg <= in_ctrl;
                        end else if (in_xfer) begin
                            state_reg     <= FULL;
                            skid_data_reg <= in_data;
                            skid_ctrl_reg <= in_ctrl;
                        end else if (out_ready) begin
                            state_reg <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (out_ready) begin
                            state_reg     <= ONE;
                            main_data_reg <= skid_data_reg;
                            main_ctrl_reg <= skid_ctrl_reg;
                        end
                    end
                    default: state_reg <= EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and reference-queue checks for pipe_stage_reg (CNT_W=4 so the
// transfer counter wraps quickly).
module tb_pipe_stage_reg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 3;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic              flush;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  xfer_count;

    int vectors;
    int miscompares;

    pipe_stage_reg #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .flush     (flush),
        .occupancy (occupancy),
        .xfer_count(xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                         input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Reference model for the random phase: a plain FIFO of {ctrl,data}.
    logic [CTRL_W+DATA_W-1:0] q[$];
    logic [CNT_W-1:0]         m_cnt;
    logic                     m_iv, m_or, m_fl;
    logic [DATA_W-1:0]        m_d;
    logic [CTRL_W-1:0]        m_c;
    logic                     m_ovalid, m_irdy;

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);

        // Reset state, including across clock edges while held
        #2;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_occ", {62'd0, occupancy}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_0001;
        in_ctrl  = 3'b111;
        #1;
        chk("rst_hold_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_hold_ctrl", {61'd0, out_ctrl}, 64'd0);
        chk("rst_hold_cnt", {60'd0, xfer_count}, 64'd0);
        in_valid = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk("rel_in_ready", {63'd0, in_ready}, 64'd1);

        // Stream A,B,C with out_ready high
        drive(1'b1, 32'hA, 3'b001, 1'b1, 1'b0);
        cyc();
        chk("strm_a_data", {32'd0, out_data}, 64'hA);
        chk("strm_a_occ", {62'd0, occupancy}, 64'd1);
        chk("strm_a_ctrl", {61'd0, out_ctrl}, 64'd1);
        drive(1'b1, 32'hB, 3'b010, 1'b1, 1'b0);
        cyc();
        chk("strm_b_data", {32'd0, out_data}, 64'hB);
        chk("strm_b_occ", {62'd0, occupancy}, 64'd1);
        drive(1'b1, 32'hC, 3'b011, 1'b1, 1'b0);
        cyc();
        chk("strm_c_data", {32'd0, out_data}, 64'hC);
        chk("strm_c_cnt", {60'd0, xfer_count}, 64'd2);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        cyc();
        chk("strm_end_cnt", {60'd0, xfer_count}, 64'd3);
        chk("strm_end_valid", {63'd0, out_valid}, 64'd0);
        chk("strm_end_ctrl", {61'd0, out_ctrl}, 64'd0);

        // Backpressure into FULL, then drain in order
        drive(1'b1, 32'h1111_AAAA, 3'b111, 1'b0, 1'b0);
        cyc();
        chk("bp_one_occ", {62'd0, occupancy}, 64'd1);
        drive(1'b1, 32'h2222_BBBB, 3'b010, 1'b0, 1'b0);
        cyc();
        chk("bp_full_occ", {62'd0, occupancy}, 64'd2);
        chk("bp_full_rdy", {63'd0, in_ready}, 64'd0);
        chk("bp_full_head", {32'd0, out_data}, 64'h1111_AAAA);
        drive(1'b1, 32'h3333_CCCC, 3'b001, 1'b0, 1'b0);
        cyc();
        chk("bp_stable_data", {32'd0, out_data}, 64'h1111_AAAA);
        chk("bp_stable_ctrl", {61'd0, out_ctrl}, 64'd7);
        chk("bp_stable_occ", {62'd0, occupancy}, 64'd2);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        cyc();
        chk("drain_b_data", {32'd0, out_data}, 64'h2222_BBBB);
        chk("drain_b_occ", {62'd0, occupancy}, 64'd1);
        chk("drain_b_rdy", {63'd0, in_ready}, 64'd1);
        cyc();
        chk("drain_occ", {62'd0, occupancy}, 64'd0);
        chk("drain_cnt", {60'd0, xfer_count}, 64'd5);

        // Flush while FULL with an offered entry D
        drive(1'b1, 32'hE, 3'b111, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 32'hF, 3'b111, 1'b0, 1'b0);
        cyc();
        chk("fl_pre_occ", {62'd0, occupancy}, 64'd2);
        drive(1'b1, 32'hD, 3'b111, 1'b0, 1'b1);
        cyc();
        chk("fl_full_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_full_ctrl", {61'd0, out_ctrl}, 64'd0);
        chk("fl_full_occ", {62'd0, occupancy}, 64'd0);
        chk("fl_full_cnt", {60'd0, xfer_count}, 64'd5);

        // Flush in ONE with simultaneous accept and output transfer
        drive(1'b1, 32'h6, 3'b101, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 32'hD, 3'b111, 1'b1, 1'b1);
        cyc();
        chk("fl_one_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_one_cnt", {60'd0, xfer_count}, 64'd6);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        cyc();
        chk("fl_one_noD", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset mid-cycle while FULL
        drive(1'b1, 32'h71, 3'b110, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 32'h72, 3'b110, 1'b0, 1'b0);
        cyc();
        chk("ar_pre_occ", {62'd0, occupancy}, 64'd2);
        #3 reset = 1'b0;
        #1;
        chk("ar_valid", {63'd0, out_valid}, 64'd0);
        chk("ar_rdy", {63'd0, in_ready}, 64'd0);
        chk("ar_occ", {62'd0, occupancy}, 64'd0);
        chk("ar_ctrl", {61'd0, out_ctrl}, 64'd0);
        chk("ar_cnt", {60'd0, xfer_count}, 64'd0);
        #1 reset = 1'b1;
        #1;
        chk("ar_rel_rdy", {63'd0, in_ready}, 64'd1);

        // 17 output transfers wrap the 4-bit counter to 1; order checked on the way
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 32'h100 + i, 3'b001, 1'b1, 1'b0);
            cyc();
            chk("wrap_order", {32'd0, out_data}, 64'h100 + 64'(i));
            if (i == 16)
                chk("wrap_zero", {60'd0, xfer_count}, 64'd0);
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        cyc();
        chk("wrap_cnt", {60'd0, xfer_count}, 64'd1);
        chk("wrap_occ", {62'd0, occupancy}, 64'd0);

        // Random traffic against the reference queue
        q.delete();
        m_cnt = 4'd1;
        for (int i = 0; i < 300; i++) begin
            m_ovalid = (q.size() != 0);
            m_irdy   = (q.size() < 2);
            chk("rnd_valid", {63'd0, out_valid}, {63'd0, m_ovalid});
            chk("rnd_rdy", {63'd0, in_ready}, {63'd0, m_irdy});
            chk("rnd_occ", {62'd0, occupancy}, 64'(q.size()));
            chk("rnd_cnt", {60'd0, xfer_count}, {60'd0, m_cnt});
            if (m_ovalid) begin
                chk("rnd_data", {32'd0, out_data}, {32'd0, q[0][DATA_W-1:0]});
                chk("rnd_ctrl", {61'd0, out_ctrl}, {61'd0, q[0][CTRL_W+DATA_W-1:DATA_W]});
            end else begin
                chk("rnd_bubble", {61'd0, out_ctrl}, 64'd0);
            end
            m_iv = ($urandom_range(0, 3) != 0);
            m_or = ($urandom_range(0, 2) != 0);
            m_fl = ($urandom_range(0, 15) == 0);
            m_d  = $urandom;
            m_c  = 3'($urandom_range(0, 7));
            drive(m_iv, m_d, m_c, m_or, m_fl);
            if (m_ovalid && m_or) begin
                void'(q.pop_front());
                m_cnt = m_cnt + 4'd1;
            end
            if (m_iv && m_irdy)
                q.push_back({m_c, m_d});
            if (m_fl)
                q.delete();
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
